// File: rtl/udma_lin_addrgen.sv
// Linear uDMA address generator: one active transfer plus one queued shadow transfer.
// Optional continuous auto-restart is built when UDMA_ADDRGEN_CONT_EN is defined.
module udma_lin_addrgen #(
  parameter int unsigned AWIDTH     = 21,
  parameter int unsigned TRANS_SIZE = 20
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [AWIDTH-1:0]     cfg_startaddr_i,
  input  logic [TRANS_SIZE-1:0] cfg_size_i,
  input  logic [1:0]            cfg_datasize_i,
  input  logic                  cfg_continuous_i,
  input  logic                  cfg_en_i,
  input  logic                  cfg_clr_i,
  input  logic                  grant_i,
  output logic                  en_o,
  output logic                  pending_o,
  output logic [AWIDTH-1:0]     curr_addr_o,
  output logic [TRANS_SIZE-1:0] bytes_left_o,
  output logic                  sot_o,
  output logic                  eot_o
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [AWIDTH-1:0]     addr_q, addr_d;
  logic [TRANS_SIZE-1:0] left_q, left_d;
  logic [1:0]            ds_q, ds_d;
  logic                  pend_q, pend_d;
  logic [AWIDTH-1:0]     sh_addr_q, sh_addr_d;
  logic [TRANS_SIZE-1:0] sh_size_q, sh_size_d;
  logic [1:0]            sh_ds_q, sh_ds_d;
  logic                  sot_q, sot_d;
  logic                  eot_q, eot_d;

  logic                  en_ok_c;
  logic [TRANS_SIZE-1:0] step_c;
  logic                  final_c;
  logic                  load_c;
  logic [AWIDTH-1:0]     load_addr_c;
  logic [TRANS_SIZE-1:0] load_size_c;
  logic [1:0]            load_ds_c;

`ifdef UDMA_ADDRGEN_CONT_EN
  logic [AWIDTH-1:0]     rl_addr_q, rl_addr_d;
  logic [TRANS_SIZE-1:0] rl_size_q, rl_size_d;
  logic [1:0]            rl_ds_q, rl_ds_d;
`else
  logic unused_cont;
  assign unused_cont = cfg_continuous_i;
`endif

  assign en_ok_c = cfg_en_i && (cfg_size_i != '0);
  assign step_c  = (ds_q == 2'b00) ? TRANS_SIZE'(1) :
                   (ds_q == 2'b01) ? TRANS_SIZE'(2) : TRANS_SIZE'(4);
  assign final_c = (left_q <= step_c);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    left_d      = left_q;
    ds_d        = ds_q;
    pend_d      = pend_q;
    sh_addr_d   = sh_addr_q;
    sh_size_d   = sh_size_q;
    sh_ds_d     = sh_ds_q;
    sot_d       = 1'b0;
    eot_d       = 1'b0;
    load_c      = 1'b0;
    load_addr_c = cfg_startaddr_i;
    load_size_c = cfg_size_i;
    load_ds_c   = cfg_datasize_i;
`ifdef UDMA_ADDRGEN_CONT_EN
    rl_addr_d   = rl_addr_q;
    rl_size_d   = rl_size_q;
    rl_ds_d     = rl_ds_q;
`endif
    if (cfg_clr_i) begin
      state_d   = IDLE;
      addr_d    = '0;
      left_d    = '0;
      ds_d      = '0;
      pend_d    = 1'b0;
      sh_addr_d = '0;
      sh_size_d = '0;
      sh_ds_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (en_ok_c) load_c = 1'b1;
        RUN: begin
          if (grant_i) begin
            addr_d = addr_q + AWIDTH'(step_c);
            left_d = final_c ? '0 : left_q - step_c;
          end
          if (grant_i && final_c) begin
            // Completion: new request beats queued shadow beats auto-reload
            eot_d = 1'b1;
            if (en_ok_c) begin
              load_c = 1'b1;
            end else if (pend_q) begin
              load_c      = 1'b1;
              load_addr_c = sh_addr_q;
              load_size_c = sh_size_q;
              load_ds_c   = sh_ds_q;
              pend_d      = 1'b0;
`ifdef UDMA_ADDRGEN_CONT_EN
            end else if (cfg_continuous_i) begin
              load_c      = 1'b1;
              load_addr_c = rl_addr_q;
              load_size_c = rl_size_q;
              load_ds_c   = rl_ds_q;
`endif
            end else begin
              state_d = IDLE;
            end
          end else if (en_ok_c) begin
            pend_d    = 1'b1;
            sh_addr_d = cfg_startaddr_i;
            sh_size_d = cfg_size_i;
            sh_ds_d   = cfg_datasize_i;
          end
        end
        default: state_d = IDLE;
      endcase
      if (load_c) begin
        state_d = RUN;
        sot_d   = 1'b1;
        addr_d  = load_addr_c;
        left_d  = load_size_c;
        ds_d    = load_ds_c;
`ifdef UDMA_ADDRGEN_CONT_EN
        rl_addr_d = load_addr_c;
        rl_size_d = load_size_c;
        rl_ds_d   = load_ds_c;
`endif
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      left_q    <= '0;
      ds_q      <= '0;
      pend_q    <= 1'b0;
      sh_addr_q <= '0;
      sh_size_q <= '0;
      sh_ds_q   <= '0;
      sot_q     <= 1'b0;
      eot_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      left_q    <= left_d;
      ds_q      <= ds_d;
      pend_q    <= pend_d;
      sh_addr_q <= sh_addr_d;
      sh_size_q <= sh_size_d;
      sh_ds_q   <= sh_ds_d;
      sot_q     <= sot_d;
      eot_q     <= eot_d;
    end
  end

`ifdef UDMA_ADDRGEN_CONT_EN
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rl_addr_q <= '0;
      rl_size_q <= '0;
      rl_ds_q   <= '0;
    end else begin
      rl_addr_q <= rl_addr_d;
      rl_size_q <= rl_size_d;
      rl_ds_q   <= rl_ds_d;
    end
  end
`endif

  assign en_o         = (state_q == RUN);
  assign pending_o    = pend_q;
  assign curr_addr_o  = addr_q;
  assign bytes_left_o = left_q;
  assign sot_o        = sot_q;
  assign eot_o        = eot_q;

endmodule

// File: doc/udma_lin_addrgen.md
UDMA_LIN_ADDRGEN -- requirements
Module: udma_lin_addrgen

Interface
REQ-001 SHALL have parameter AWIDTH, default 21, L2 byte-address width (L2_AWIDTH_NOAL).
REQ-002 SHALL have parameter TRANS_SIZE, default 20, transfer-size and byte-counter width.
REQ-003 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rstn_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cfg_startaddr_i  input  AWIDTH  transfer start byte address.
REQ-006 SHALL have port cfg_size_i  input  TRANS_SIZE  transfer length in bytes.
REQ-007 SHALL have port cfg_datasize_i  input  2  beat size: 00 byte, 01 half, 10 word, 11 treated as word.
REQ-008 SHALL have port cfg_continuous_i  input  1  auto-restart on completion.
REQ-009 SHALL have port cfg_en_i  input  1  one-cycle pulse, enqueue transfer.
REQ-010 SHALL have port cfg_clr_i  input  1  one-cycle pulse, abort all.
REQ-011 SHALL have port grant_i  input  1  one beat consumed this cycle.
REQ-012 SHALL have ports en_o (1, channel running), pending_o (1, shadow transfer queued), curr_addr_o (AWIDTH), bytes_left_o (TRANS_SIZE), sot_o (1, start-of-transfer pulse), eot_o (1, end-of-transfer pulse), all outputs.

Function
REQ-013 SHALL implement FSM IDLE/RUN; en_o=1 exactly in RUN.
REQ-014 SHALL ignore cfg_en_i when cfg_size_i=0.
REQ-015 In IDLE, cfg_en_i SHALL load addr/size/datasize and enter RUN next cycle, with sot_o=1 that same cycle.
REQ-016 In RUN, grant_i SHALL add step (1/2/4 per latched datasize) to curr_addr_o, modulo 2^AWIDTH, and subtract step from bytes_left_o.
REQ-017 A grant with bytes_left_o <= step is the final beat; bytes_left_o SHALL saturate at 0, never wrap.
REQ-018 eot_o SHALL pulse one cycle, in the cycle after the final grant.
REQ-019 After the final beat, priority: cfg_en_i same cycle > pending shadow > continuous reload > IDLE.
REQ-020 On restart, RUN SHALL be held and sot_o SHALL pulse in the same cycle as eot_o; a consumed shadow clears pending_o.
REQ-021 cfg_en_i in RUN, not on the final beat, SHALL capture the shadow and set pending_o; a later cfg_en_i while pending SHALL overwrite the shadow.
REQ-022 grant_i in IDLE SHALL be ignored.
REQ-023 cfg_clr_i SHALL override all inputs: next cycle IDLE, pending_o=0, curr_addr_o=0, bytes_left_o=0, no eot_o/sot_o.
REQ-024 Zero-to-one latency from grant_i to updated curr_addr_o: one cycle (registered).

Reset
REQ-025 On rstn_i low, all outputs and internal registers SHALL be 0 and FSM IDLE, immediately and independent of clk_i.
REQ-026 Reset mid-transfer SHALL discard the active transfer and shadow with no eot_o.

Configuration
REQ-027 Macro UDMA_ADDRGEN_CONT_EN defined: continuous mode per REQ-019, start address/size retained in reload registers.
REQ-028 Macro undefined: cfg_continuous_i ignored, reload registers absent, completion without pending/cfg_en_i SHALL go IDLE.

Verification
REQ-029 start=0x100, size=8, ds=10, grant every cycle -> addr 0x100,0x104; eot_o 1 cycle after 2nd grant; en_o=0 after.
REQ-030 start=0x1FFFFE, size=4, ds=01 -> addr 0x1FFFFE then 0x000000 (wrap); bytes_left 4,2,0.
REQ-031 size=5, ds=10 -> bytes_left 5,1,0; two beats; eot_o once.
REQ-032 Running, cfg_en_i(start=0x200,size=2,ds=00) -> pending_o=1; at end eot_o and sot_o same cycle, addr=0x200, pending_o=0.
REQ-033 Continuous (macro on), start=0x40,size=4,ds=10 -> after grant eot_o+sot_o, addr back to 0x40; cfg_clr_i -> IDLE, outputs 0, no eot_o.
REQ-034 rstn_i low mid-transfer with pending -> all outputs 0 asynchronously; after release grant_i has no effect.
